tcp_frame_responder: RTL and testbench

Synthesizable responder for the 32-bit word stream carried by the VPI TCP server tasks. It accepts request frames word-by-word from the receive side, the words returned by `$recv_tcp_server`. It returns a response frame on the send side, the words handed to `$send_tcp_server`. Payload is buffered in a FIFO so the send side may stall. It is the device-side counterpart to the bench's receive/send loop.

---
 rtl/tcp_frame_responder.sv | 200 ++++++++++++++++++++
 tb/tb_tcp_frame_responder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_frame_responder.sv
// Device-side responder for the 32-bit TCP word stream: echoes request frames as response frames through a FIFO.
// Define TCP_FRAME_CHECKSUM_EN to append a 32-bit payload-sum trailer to every response frame.
module tcp_frame_responder #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        frame_err,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

`ifdef TCP_FRAME_CHECKSUM_EN
  typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD, ST_TRAILER, ST_DISCARD} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD, ST_DISCARD} state_t;
`endif

  state_t        state_q, state_d;
  logic [15:0]   rem_q, rem_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          frame_err_q, frame_err_d;
`ifdef TCP_FRAME_CHECKSUM_EN
  logic [31:0]   sum_q, sum_d;
`endif

  logic [31:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] mem_cnt_q, mem_cnt_d;
  logic [31:0]   m_data_q, m_data_d;
  logic          m_valid_q, m_valid_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          s_ready_int;
  logic          s_fire;
  logic          wr_en;
  logic [31:0]   wr_word;
  logic          pop, load_out, mem_rd, bypass, mem_wr;

  // The output register is the head slot of the FIFO, so it counts toward occupancy.
  assign fifo_count  = mem_cnt_q + CW'(m_valid_q);
  assign fifo_full   = (fifo_count >= CW'(FIFO_DEPTH));
  assign s_ready_int = ((state_q == ST_IDLE || state_q == ST_PAYLOAD) && !fifo_full)
                       || (state_q == ST_DISCARD);
  assign s_ready     = !rst && s_ready_int;
  assign s_fire      = s_valid && s_ready_int;

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;
  assign busy      = !rst && ((state_q != ST_IDLE) || (fifo_count != '0));

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    frame_cnt_d = frame_cnt_q;
    frame_err_d = 1'b0;
`ifdef TCP_FRAME_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    wr_en       = 1'b0;
    wr_word     = '0;

    case (state_q)
      ST_IDLE: begin
        if (s_fire) begin
          rem_d = s_data[15:0];
          if (s_data[31]) begin
            frame_err_d = 1'b1;
            if (s_data[15:0] != 16'd0) state_d = ST_DISCARD;
          end else begin
            wr_en   = 1'b1;
            wr_word = {1'b1, s_data[30:0]};
`ifdef TCP_FRAME_CHECKSUM_EN
            sum_d   = '0;
            state_d = (s_data[15:0] != 16'd0) ? ST_PAYLOAD : ST_TRAILER;
`else
            if (s_data[15:0] != 16'd0) begin
              state_d = ST_PAYLOAD;
            end else begin
              frame_cnt_d = frame_cnt_q + 16'd1;
            end
`endif
          end
        end
      end

      ST_PAYLOAD: begin
        if (s_fire) begin
          wr_en   = 1'b1;
          wr_word = s_data;
          rem_d   = rem_q - 16'd1;
`ifdef TCP_FRAME_CHECKSUM_EN
          sum_d   = sum_q + s_data;
          if (rem_q == 16'd1) state_d = ST_TRAILER;
`else
          if (rem_q == 16'd1) begin
            state_d     = ST_IDLE;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
`endif
        end
      end

`ifdef TCP_FRAME_CHECKSUM_EN
      ST_TRAILER: begin
        if (!fifo_full) begin
          wr_en       = 1'b1;
          wr_word     = sum_q;
          state_d     = ST_IDLE;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
`endif

      ST_DISCARD: begin
        if (s_fire) begin
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // A write into an idle head slot bypasses storage so latency stays at one cycle.
  always_comb begin
    pop       = m_valid_q && m_ready;
    load_out  = !m_valid_q || pop;
    mem_rd    = load_out && (mem_cnt_q != '0);
    bypass    = load_out && (mem_cnt_q == '0) && wr_en;
    mem_wr    = wr_en && !bypass;

    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    if (load_out) begin
      if (mem_rd) begin
        m_data_d  = mem[rd_ptr_q];
        m_valid_d = 1'b1;
      end else if (bypass) begin
        m_data_d  = wr_word;
        m_valid_d = 1'b1;
      end else begin
        m_valid_d = 1'b0;
      end
    end

    wr_ptr_d  = mem_wr ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = mem_rd ? rd_ptr_q + PW'(1) : rd_ptr_q;
    mem_cnt_d = mem_cnt_q + CW'(mem_wr) - CW'(mem_rd);
  end

  always_ff @(posedge clk) begin
    if (mem_wr) mem[wr_ptr_q] <= wr_word;
  end

`ifdef TCP_FRAME_CHECKSUM_EN
  always_ff @(posedge clk) begin
    sum_q <= sum_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      frame_cnt_q <= '0;
      frame_err_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      frame_cnt_q <= frame_cnt_d;
      frame_err_q <= frame_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_cnt_q   <= mem_cnt_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
    end
  end

endmodule

// File: tb/tb_tcp_frame_responder.sv
// Scoreboard bench for tcp_frame_responder: frame-level reference model feeds an expected-word queue.
module tb_tcp_frame_responder;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        frame_err;
  logic [15:0] frame_cnt;
  logic        busy;

  tcp_frame_responder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .frame_err(frame_err), .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic        err_expect = 1'b0;
  bit          mr_force0 = 1'b1;
  bit          mr_force1 = 1'b0;
  logic [15:0] model_cnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    m_ready = mr_force0 ? 1'b0 : (mr_force1 ? 1'b1 : ($urandom_range(3) != 0));
  end

  // Monitor: a response transfer happens at the next rising edge when valid and ready are seen here.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL m_data: got unexpected word %h, required no word", m_data);
        end else begin
          chk("m_data", m_data, exp_q.pop_front());
        end
      end
      if (frame_err || err_expect) chk("frame_err", 32'(frame_err), 32'(err_expect));
      err_expect = 1'b0;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic gap(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit bad_hdr);
    int n = 0;
    s_data  = w;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 400) begin
      n++;
      @(negedge clk);
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL s_ready timeout: got 0 for word %h, required 1", w);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    if (bad_hdr) err_expect = 1'b1;
  endtask

  // Reference model: response = marked header, echoed payload, optional sum trailer; rejected frames vanish.
  task automatic model_frame(input logic [31:0] hdr, input logic [31:0] pl[$]);
    logic [31:0] sum = '0;
    if (!hdr[31]) begin
      exp_q.push_back({1'b1, hdr[30:0]});
      foreach (pl[i]) begin
        exp_q.push_back(pl[i]);
        sum = sum + pl[i];
      end
`ifdef TCP_FRAME_CHECKSUM_EN
      exp_q.push_back(sum);
`endif
      model_cnt = model_cnt + 16'd1;
    end
  endtask

  task automatic send_frame(input logic [31:0] hdr, input logic [31:0] pl[$], input bit gaps);
    model_frame(hdr, pl);
    send_word(hdr, hdr[31]);
    foreach (pl[i]) begin
      if (gaps && $urandom_range(3) == 0) gap($urandom_range(1, 3));
      send_word(pl[i], 1'b0);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && n < 3000) begin
      n++;
      @(negedge clk);
    end
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " pending words"}, 32'(exp_q.size()), 32'd0);
    chk({tag, " frame_cnt"}, 32'(frame_cnt), 32'(model_cnt));
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst     = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    chk("s_ready in reset", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    model_cnt = '0;
    @(negedge clk);
    chk("m_valid after reset", 32'(m_valid), 32'd0);
    chk("busy after reset", 32'(busy), 32'd0);
    chk("frame_cnt after reset", 32'(frame_cnt), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] pl[$];
    logic [31:0] hdr;
    int          n;
    int          nwrap;

    // Power-on reset
    repeat (2) @(negedge clk);
    chk("s_ready in reset", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("m_data reset", m_data, 32'd0);
    chk("m_valid reset", 32'(m_valid), 32'd0);
    chk("frame_cnt reset", 32'(frame_cnt), 32'd0);
    chk("busy reset", 32'(busy), 32'd0);
    chk("frame_err reset", 32'(frame_err), 32'd0);
    @(posedge clk);
    #1;
    mr_force0 = 1'b0;
    mr_force1 = 1'b1;
    gap(1);

    // Basic three-word echo
    pl = '{32'h11111111, 32'h22222222, 32'h33333333};
    send_frame(32'h00000003, pl, 1'b0);
    wait_idle("basic");

    // Rejected header then an empty request
    pl = '{32'hDEADBEEF, 32'h12345678};
    send_frame(32'h80000002, pl, 1'b0);
    pl = '{};
    send_frame(32'h00000000, pl, 1'b0);
    wait_idle("reject");

    // Backpressure: FIFO fills with N=20 while the sink is stalled
    mr_force1 = 1'b0;
    mr_force0 = 1'b1;
    gap(1);
    pl = '{};
    for (int i = 0; i < 20; i++) pl.push_back($urandom);
    model_frame(32'h00000014, pl);
    send_word(32'h00000014, 1'b0);
    for (int i = 0; i < 15; i++) send_word(pl[i], 1'b0);
    s_data  = pl[15];
    s_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("s_ready when full", 32'(s_ready), 32'd0);
    chk("m_valid when full", 32'(m_valid), 32'd1);
    @(posedge clk);
    #1;
    mr_force0 = 1'b0;
    for (int i = 15; i < 20; i++) send_word(pl[i], 1'b0);
    wait_idle("full");

    // Sum wraps modulo 2^32
    pl = '{32'hFFFFFFFF, 32'h00000002};
    send_frame(32'h00000002, pl, 1'b0);
    wait_idle("sumwrap");

    // Reset in the middle of a frame
    mr_force0 = 1'b1;
    gap(1);
    send_word(32'h00000005, 1'b0);
    send_word(32'h01010101, 1'b0);
    send_word(32'h02020202, 1'b0);
    pulse_reset();
    mr_force0 = 1'b0;
    pl = '{32'hAAAAAAAA};
    send_frame(32'h00000001, pl, 1'b0);
    wait_idle("midreset");

    // Randomized frames with random sink stalls and source gaps
    for (int f = 0; f < 40; f++) begin
      n   = $urandom_range(0, 6);
      hdr = {($urandom_range(4) == 0), 15'($urandom), 16'(n)};
      pl  = '{};
      for (int i = 0; i < n; i++) pl.push_back($urandom);
      send_frame(hdr, pl, 1'b1);
    end
    wait_idle("random");

    // frame_cnt wrap with back-to-back empty requests
    mr_force1 = 1'b1;
    gap(1);
    pulse_reset();
`ifdef TCP_FRAME_CHECKSUM_EN
    nwrap = 300;
`else
    nwrap = 32'h0000FFFF;
`endif
    pl = '{};
    for (int f = 0; f < nwrap; f++) send_frame({1'b0, 15'($urandom), 16'h0000}, pl, 1'b0);
    wait_idle("count");
    send_frame(32'h00000000, pl, 1'b0);
    wait_idle("count wrap");
`ifndef TCP_FRAME_CHECKSUM_EN
    chk("frame_cnt wrapped", 32'(frame_cnt), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
